// File: rtl/hps_pkg.sv
// Shared definitions for the HPS divider: mode encodings, lane geometry,
// step counts and the control FSM states.
package hps_pkg;

    // Mode encodings, identical to the HPS 4x4 multiplier.
    localparam logic HPS_MODE_DUAL = 1'b0;
    localparam logic HPS_MODE_FULL = 1'b1;

    // Divisor widths: one 4-bit divisor in full mode, two 2-bit lane divisors in dual mode.
    localparam int HPS_FULL_DW   = 4;
    localparam int HPS_LANE_DW   = 2;
    localparam int HPS_NUM_LANES = 2;

    // One restoring step per dividend bit.
    localparam logic [3:0] HPS_STEPS_FULL = 4'd8;
    localparam logic [3:0] HPS_STEPS_DUAL = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } hps_state_e;

endpackage

// File: rtl/hps_div_8x4_if.sv
// Operand/result handshake bundle for the HPS 8x4 divider.
// master = producer/consumer side, slave = divider side.
interface hps_div_8x4_if;

    logic       in_valid;
    logic       in_ready;
    logic       mode;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic [1:0] div_by_zero;

    modport master (
        output in_valid, mode, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, mode, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/hps_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, subtract the divisor if it fits.
// The remainder is DW+1 bits wide so the pre-subtract shifted value
// (< 2*D) never overflows.
module hps_div_step #(
    parameter int DW = 4
) (
    input  logic [DW:0]   i_rem,
    input  logic          i_bit,
    input  logic [DW-1:0] i_div,
    output logic [DW:0]   o_rem,
    output logic          o_q
);

    logic [DW+1:0] w_shift;
    logic [DW+1:0] w_diff;
    logic [DW+1:0] w_sel;
    logic          w_unused;

    assign w_shift = {i_rem, i_bit};
    assign w_diff  = w_shift - {2'b00, i_div};
    assign o_q     = (w_shift >= {2'b00, i_div});
    assign w_sel   = o_q ? w_diff : w_shift;
    assign o_rem   = w_sel[DW:0];

    // Top bit of the selected value is always zero while R < D holds.
    assign w_unused = w_sel[DW+1];

endmodule

// File: rtl/hps_div_8x4.sv
// Sequential restoring divider, inverse of the HPS 4x4 multiplier.
// Full mode: 8-bit / 4-bit. Dual mode: two independent 4-bit / 2-bit lanes.
// The dividend register doubles as the quotient register: each step shifts
// a dividend bit out of the top of a lane and a quotient bit into its bottom.
module hps_div_8x4
    import hps_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    hps_div_8x4_if.slave io_bus
);

    hps_state_e r_state;
    hps_state_e w_next;

    logic                                    r_mode;
    logic [7:0]                              r_dd;
    logic [3:0]                              r_div;
    logic [HPS_FULL_DW:0]                    r_rem_f;
    logic [HPS_NUM_LANES-1:0][HPS_LANE_DW:0] r_rem_l;
    logic [3:0]                              r_cnt;
    logic [7:0]                              r_quot;
    logic [3:0]                              r_remo;
    logic [1:0]                              r_dbz;

    logic [HPS_FULL_DW:0]                    w_rf_nx;
    logic                                    w_qf;
    logic [HPS_NUM_LANES-1:0][HPS_LANE_DW:0] w_rl_nx;
    logic [HPS_NUM_LANES-1:0]                w_ql;
    logic [7:0]                              w_dd_nx;
    logic [7:0]                              w_res_q;
    logic [3:0]                              w_res_r;
    logic [1:0]                              w_res_z;
    logic                                    w_last;
    logic                                    w_unused;

    assign w_last = (r_cnt == 4'd1);

    // Full-precision step: 5-bit R against the whole 4-bit divisor.
    hps_div_step #(.DW(HPS_FULL_DW)) u_step_full (
        .i_rem (r_rem_f),
        .i_bit (r_dd[7]),
        .i_div (r_div),
        .o_rem (w_rf_nx),
        .o_q   (w_qf)
    );

    // Lane steps: 3-bit R per lane, no carries cross between lanes.
    for (genvar g = 0; g < HPS_NUM_LANES; g++) begin : g_lane
        hps_div_step #(.DW(HPS_LANE_DW)) u_step (
            .i_rem (r_rem_l[g]),
            .i_bit (r_dd[g*4+3]),
            .i_div (r_div[g*2 +: 2]),
            .o_rem (w_rl_nx[g]),
            .o_q   (w_ql[g])
        );
    end

    // After the last step R is below D, so the top remainder bits are zero.
    assign w_unused = ^{w_rf_nx[HPS_FULL_DW], w_rl_nx[1][HPS_LANE_DW], w_rl_nx[0][HPS_LANE_DW]};

    // Next shift value of the dividend/quotient register and the result
    // captured on the final step, with per-lane divide-by-zero override.
    always_comb begin
        w_dd_nx = {r_dd[6:4], w_ql[1], r_dd[2:0], w_ql[0]};
        w_res_q = w_dd_nx;
        w_res_r = {w_rl_nx[1][1:0], w_rl_nx[0][1:0]};
        w_res_z = 2'b00;
        if (r_mode == HPS_MODE_FULL) begin
            w_dd_nx = {r_dd[6:0], w_qf};
            w_res_q = w_dd_nx;
            w_res_r = w_rf_nx[3:0];
            if (r_div == 4'd0) begin
                w_res_q = 8'hFF;
                w_res_r = 4'h0;
                w_res_z = 2'b01;
            end
        end else begin
            for (int l = 0; l < HPS_NUM_LANES; l++) begin
                if (r_div[l*2 +: 2] == 2'b00) begin
                    w_res_q[l*4 +: 4] = 4'hF;
                    w_res_r[l*2 +: 2] = 2'b00;
                    w_res_z[l]        = 1'b1;
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next state plus handshake decodes; ready/valid come straight from the state.
    always_comb begin
        w_next           = r_state;
        io_bus.in_ready  = 1'b0;
        io_bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                io_bus.in_ready = 1'b1;
                if (io_bus.in_valid) w_next = ST_CALC;
            end
            ST_CALC: begin
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                io_bus.out_valid = 1'b1;
                if (io_bus.out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture at acceptance, then one restoring step per CALC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode  <= HPS_MODE_DUAL;
            r_dd    <= '0;
            r_div   <= '0;
            r_rem_f <= '0;
            r_rem_l <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.in_valid) begin
                        r_mode  <= io_bus.mode;
                        r_dd    <= io_bus.dividend;
                        r_div   <= io_bus.divisor;
                        r_rem_f <= '0;
                        r_rem_l <= '0;
                        r_cnt   <= (io_bus.mode == HPS_MODE_FULL) ? HPS_STEPS_FULL : HPS_STEPS_DUAL;
                    end
                end
                ST_CALC: begin
                    r_dd  <= w_dd_nx;
                    r_cnt <= r_cnt - 4'd1;
                    if (r_mode == HPS_MODE_FULL) r_rem_f <= w_rf_nx;
                    else                         r_rem_l <= w_rl_nx;
                end
                default: ;
            endcase
        end
    end

    // Result registers: loaded on the last step, held until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quot <= '0;
            r_remo <= '0;
            r_dbz  <= '0;
        end else if (r_state == ST_CALC && w_last) begin
            r_quot <= w_res_q;
            r_remo <= w_res_r;
            r_dbz  <= w_res_z;
        end
    end

    assign io_bus.quotient    = r_quot;
    assign io_bus.remainder   = r_remo;
    assign io_bus.div_by_zero = r_dbz;

endmodule
